bidirectional_serializer: RTL and testbench

Parallel-in, serial-out shifter: the transmit-side counterpart of the team's serial-in/parallel-out bidirectional shift register. It accepts a WIDTH-bit word on a load handshake and emits it one bit per clock, MSB-first or LSB-first, with valid/last framing. With the matching shift direction, a downstream bidirectional shift register reassembles the word. It feeds serial links and loopback benches in the shift-register series.

---
 rtl/bidirectional_serializer.sv | 84 ++++++++
 tb/tb_bidirectional_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bidirectional_serializer.sv
// Parallel-in, serial-out shifter with valid/last framing and MSB/LSB-first order.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module bidirectional_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] datain,
   input  logic             mode,
   output logic             ready,
   output logic             dataout,
   output logic             valid,
   output logic             last
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIALIZER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             mode_r;
   logic             accept;
   logic             data_bit;

   assign valid  = (state == SHIFT);
   assign last   = valid && (cnt == LAST_CNT);
   assign ready  = (state == IDLE) || last;
   assign accept = load && ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg  <= '0;
         cnt    <= '0;
         mode_r <= 1'b0;
      end else if (accept) begin
         shreg  <= datain;
         mode_r <= mode;
         cnt    <= '0;
      end else if (state == SHIFT) begin
         shreg <= mode_r ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
         cnt   <= last ? '0 : cnt + 1'b1;
      end
   end

   assign data_bit = mode_r ? shreg[WIDTH-1] : shreg[0];

`ifdef SERIALIZER_PARITY_EN
   logic par_r;

   // Parity is taken from the captured word, since shreg drains as it shifts.
   always_ff @(posedge clk) begin
      if (reset)       par_r <= 1'b0;
      else if (accept) par_r <= ^datain;
   end

   assign dataout = valid && ((cnt == CW'(WIDTH)) ? par_r : data_bit);
`else
   assign dataout = valid && data_bit;
`endif

endmodule

// File: tb/tb_bidirectional_serializer.sv
// Scoreboard bench: stimulus pushes expected frame bits, a monitor pops and compares.
module tb_bidirectional_serializer;
   localparam int WIDTH = 4;
`ifdef SERIALIZER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1, load = 1'b1, mode = 1'b0;
   logic [WIDTH-1:0] datain = '0;
   logic ready, dataout, valid, last;

   bidirectional_serializer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .load(load), .datain(datain), .mode(mode),
      .ready(ready), .dataout(dataout), .valid(valid), .last(last)
   );

   always #5 clk = ~clk;

   // Each entry is {expected dataout, expected last}.
   logic [1:0] sb[$];
   int rem = 0;
   int n_cmp = 0, n_err = 0;
   bit armed = 0;
   bit done = 0;

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Expected bit stream of one frame, straight from the word and order.
   task automatic push_frame(input logic [WIDTH-1:0] d, input logic m);
      for (int i = 0; i < WIDTH; i++) begin
         int idx = m ? (WIDTH - 1 - i) : i;
         sb.push_back({d[idx], (i == FRAME - 1) ? 1'b1 : 1'b0});
      end
`ifdef SERIALIZER_PARITY_EN
      sb.push_back({^d, 1'b1});
`endif
   endtask

   // One clock: check ready, drive inputs, advance the model at the edge.
   task automatic cycle(input logic r, input logic l, input logic [WIDTH-1:0] d, input logic m);
      bit rdy;
      @(negedge clk);
      rdy = (rem <= 1);
      if (armed) check("ready", ready, rdy);
      reset = r; load = l; datain = d; mode = m;
      @(posedge clk);
      if (r) begin
         sb.delete();
         rem = 0;
      end else if (l && rdy) begin
         push_frame(d, m);
         rem = FRAME;
      end else if (rem > 0) begin
         rem--;
      end
   endtask

   // Monitor
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (done) break;
         if (!armed) continue;
         if (valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("dataout", dataout, e[1]);
               check("last", last, e[0]);
            end
         end else begin
            check("idle_dataout", dataout, 0);
            check("idle_last", last, 0);
            check("missing_bits", sb.size(), 0);
         end
      end
   end

   initial begin
      // Reset for two cycles with load held high.
      cycle(1, 1, 4'b1011, 1);
      armed = 1;
      cycle(1, 1, 4'b1011, 1);
      cycle(0, 0, 4'b0000, 0);
      // MSB-first then LSB-first
      cycle(0, 1, 4'b1011, 1);
      repeat (FRAME + 1) cycle(0, 0, 4'b0000, 0);
      cycle(0, 1, 4'b1011, 0);
      repeat (FRAME + 1) cycle(0, 0, 4'b1111, 1);
      // Busy-ignore and gapless back-to-back
      cycle(0, 1, 4'b1100, 1);
      cycle(0, 0, 4'b0000, 0);
      cycle(0, 1, 4'b0001, 1);
      repeat (FRAME - 3) cycle(0, 0, 4'b0000, 0);
      cycle(0, 1, 4'b0110, 0);
      repeat (FRAME + 1) cycle(0, 0, 4'b0000, 0);
      // Reset mid-frame, then a fresh frame
      cycle(0, 1, 4'b1111, 1);
      cycle(0, 0, 4'b0000, 0);
      cycle(1, 0, 4'b0000, 0);
      cycle(0, 0, 4'b0000, 0);
      cycle(0, 1, 4'b1000, 1);
      repeat (FRAME + 1) cycle(0, 0, 4'b0000, 0);
      // Parity-zero word
      cycle(0, 1, 4'b1001, 1);
      repeat (FRAME + 1) cycle(0, 0, 4'b0000, 0);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic r, l, m;
         logic [WIDTH-1:0] d;
         r = ($urandom_range(0, 39) == 0);
         l = ($urandom_range(0, 2) != 0);
         m = 1'($urandom);
         d = WIDTH'($urandom);
         cycle(r, l, d, m);
      end
      repeat (FRAME + 2) cycle(0, 0, 4'b0000, 0);
      @(negedge clk);
      done = 1;
      check("drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
